// File: rtl/mux_pkg.sv
// Shared sizing constants for the round-robin demultiplexer.
package mux_pkg;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef logic [SEL_W-1:0] lane_idx_t;

endpackage

// File: rtl/demux_rr_if.sv
// Source/sink bundle for demux_rr: one input stream fanned out to WAYS lanes.
interface demux_rr_if
  import mux_pkg::*;
#(
  parameter int unsigned size = 8
);

  logic [size-1:0]      in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 rr_mode;
  logic [SEL_W-1:0]     sel;
  logic [WAYS*size-1:0] out_data;
  logic [WAYS-1:0]      out_valid;
  logic [WAYS-1:0]      out_ready;
  logic [SEL_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     xfer_cnt;

  // Environment side: drives the source word and the lane sinks.
  modport master (
    output in_data, in_valid, rr_mode, sel, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr, xfer_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_valid, rr_mode, sel, out_ready,
    output in_ready, out_data, out_valid, rr_ptr, xfer_cnt
  );

endinterface

// File: rtl/demux_rr_lane.sv
// One output lane: single-entry holding register with load, drain and valid flag.
module demux_lane #(
  parameter int unsigned size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [size-1:0] data_i,
  input  logic            drain_i,
  output logic            valid_o,
  output logic [size-1:0] data_o
);

  logic            valid_q, valid_d;
  logic [size-1:0] data_q, data_d;

  // Next state: a load in the same cycle as a drain wins, so the lane never bubbles.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (drain_i) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // Lane register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_rr.sv
// 1-to-4 demultiplexer: each accepted word goes to the round-robin lane or the
// explicitly selected lane; lanes hold one word each and drain independently.
module demux_rr
  import mux_pkg::*;
#(
  parameter int unsigned size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [size-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 rr_mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WAYS*size-1:0] out_data,
  output logic [WAYS-1:0]      out_valid,
  input  logic [WAYS-1:0]      out_ready,
  output logic [SEL_W-1:0]     rr_ptr,
  output logic [CNT_W-1:0]     xfer_cnt
);

  lane_idx_t        tgt;
  logic             accept;
  logic [WAYS-1:0]  load;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Target lane, handshake and counter next-state; in_ready never looks at in_valid.
  always_comb begin
    tgt      = rr_mode ? rr_ptr_q : sel;
    in_ready = !rst && (!out_valid[tgt] || out_ready[tgt]);
    accept   = in_valid && in_ready;
    load     = '0;
    if (accept) load[tgt] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (accept && rr_mode) rr_ptr_d = rr_ptr_q + SEL_W'(1);
    cnt_d = cnt_q;
    if (accept) cnt_d = cnt_q + CNT_W'(1);
  end

  // Round-robin pointer and transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar k = 0; k < WAYS; k++) begin : g_lane
    demux_lane #(.size(size)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[k]),
      .data_i  (in_data),
      .drain_i (out_valid[k] && out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*size +: size])
    );
  end

  assign rr_ptr   = rr_ptr_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux_rr.sv
// Directed bench for demux_rr with a per-lane scoreboard and a small reference model.
module tb_demux_rr;
  import mux_pkg::*;

  localparam int unsigned SZ = 8;

  logic clk = 1'b0;
  logic rst;

  demux_rr_if #(.size(SZ)) bus ();

  demux_rr #(.size(SZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .rr_mode   (bus.rr_mode),
    .sel       (bus.sel),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .rr_ptr    (bus.rr_ptr),
    .xfer_cnt  (bus.xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SZ-1:0]    q [WAYS][$];
  logic [WAYS-1:0]  exp_valid;
  logic [SEL_W-1:0] exp_ptr;
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < WAYS; k++) q[k].delete();
    exp_valid = '0;
    exp_ptr   = '0;
    exp_cnt   = '0;
  endtask

  // One clock: compare at negedge against the model, advance the model, then move to just after posedge.
  task automatic step();
    logic [SEL_W-1:0] t;
    logic             rdy;
    @(negedge clk);
    t   = bus.rr_mode ? exp_ptr : bus.sel;
    rdy = !exp_valid[t] || bus.out_ready[t];
    check("in_ready",  32'(bus.in_ready),  32'(rdy));
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("rr_ptr",    32'(bus.rr_ptr),    32'(exp_ptr));
    check("xfer_cnt",  32'(bus.xfer_cnt),  32'(exp_cnt));
    for (int k = 0; k < WAYS; k++) begin
      if (exp_valid[k]) begin
        check("lane_data", 32'(bus.out_data[k*SZ +: SZ]), 32'(q[k][0]));
        if (bus.out_ready[k]) begin
          void'(q[k].pop_front());
          exp_valid[k] = 1'b0;
        end
      end
    end
    if (bus.in_valid && rdy) begin
      q[t].push_back(bus.in_data);
      exp_valid[t] = 1'b1;
      exp_cnt++;
      if (bus.rr_mode) exp_ptr++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SZ-1:0] words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.rr_mode   = 1'b1;
    bus.sel       = '0;
    bus.out_ready = '0;
    model_reset();

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data",  bus.out_data,       32'h0);
    check("rst_rr_ptr",    32'(bus.rr_ptr),    32'h0);
    check("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin back-to-back, all sinks ready
    bus.rr_mode   = 1'b1;
    bus.out_ready = 4'hF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = words[i];
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("rr_cnt5", 32'(bus.xfer_cnt), 32'd5);
    check("rr_ptr1", 32'(bus.rr_ptr),   32'd1);

    // Explicit lane 2 with sink stalled
    bus.rr_mode   = 1'b0;
    bus.sel       = 2'd2;
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    step();
    bus.in_data = 8'h5A;
    step();
    check("stall_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b0;
    step();
    check("stall_lane2", 32'(bus.out_data[2*SZ +: SZ]), 32'h5A);
    bus.out_ready = 4'hF;
    step();

    // Simultaneous drain and reload on lane 1
    bus.sel       = 2'd1;
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h10;
    step();
    bus.out_ready = 4'b0010;
    bus.in_data   = 8'h20;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'h0;
    step();
    check("reload_valid1", 32'(bus.out_valid[1]),          32'h1);
    check("reload_data1",  32'(bus.out_data[1*SZ +: SZ]),  32'h20);
    check("reload_cnt",    32'(bus.xfer_cnt),              32'd9);
    bus.out_ready = 4'hF;
    step();

    // Mode switch with rr_ptr at 3
    bus.rr_mode  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    step();
    bus.in_data = 8'h02;
    step();
    check("ptr_at3", 32'(bus.rr_ptr), 32'd3);
    bus.rr_mode = 1'b0;
    bus.sel     = 2'd0;
    bus.in_data = 8'h77;
    step();
    bus.in_valid = 1'b0;
    check("mode_lane0",  32'(bus.out_data[0 +: SZ]), 32'h77);
    check("mode_ptr3",   32'(bus.rr_ptr),            32'd3);
    step();

    // Counter wrap
    bus.rr_mode  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++) begin
      bus.in_data = SZ'($urandom);
      step();
    end
    check("cnt_ffff", 32'(bus.xfer_cnt), 32'hFFFF);
    bus.in_data = 8'h3C;
    step();
    bus.in_valid = 1'b0;
    check("cnt_wrap", 32'(bus.xfer_cnt), 32'h0);
    step();

    // Asynchronous reset mid-operation
    bus.rr_mode   = 1'b0;
    bus.out_ready = 4'h0;
    bus.in_valid  = 1'b1;
    bus.sel       = 2'd0;
    bus.in_data   = 8'hC0;
    step();
    bus.sel     = 2'd2;
    bus.in_data = 8'hC2;
    step();
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'b0101);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_out_data",  bus.out_data,       32'h0);
    check("arst_rr_ptr",    32'(bus.rr_ptr),    32'h0);
    check("arst_xfer_cnt",  32'(bus.xfer_cnt),  32'h0);
    check("arst_in_ready",  32'(bus.in_ready),  32'h0);
    model_reset();
    bus.rr_mode  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_drop_valid", 32'(bus.out_valid), 32'h0);
    check("rst_drop_cnt",   32'(bus.xfer_cnt),  32'h0);
    rst         = 1'b0;
    bus.in_data = 8'h99;
    step();
    bus.in_valid = 1'b0;
    check("post_rst_lane0", 32'(bus.out_valid), 32'b0001);
    step();
    bus.out_ready = 4'hF;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_rr.md
DEMUX_RR -- requirements
Module: demux_rr

Interface
REQ-001 SHALL have parameter: size, 8, data width in bits of each lane.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_data  input  size  source data word.
REQ-005 SHALL have port: in_valid  input  1  source word present.
REQ-006 SHALL have port: in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port: rr_mode  input  1  1 = round-robin lane choice, 0 = explicit lane choice.
REQ-008 SHALL have port: sel  input  2  explicit target lane, used when rr_mode=0.
REQ-009 SHALL have port: out_data  output  4*size  lane k data at bits [k*size +: size].
REQ-010 SHALL have port: out_valid  output  4  per-lane word present.
REQ-011 SHALL have port: out_ready  input  4  per-lane sink accepts.
REQ-012 SHALL have port: rr_ptr  output  2  current round-robin pointer.
REQ-013 SHALL have port: xfer_cnt  output  16  count of accepted input words.

Function
REQ-014 SHALL select target lane t = rr_ptr when rr_mode=1, else t = sel; mode and sel changes take effect in the same cycle.
REQ-015 SHALL drive in_ready = !out_valid[t] | out_ready[t]; in_ready SHALL NOT depend combinationally on in_valid.
REQ-016 SHALL accept a word when in_valid & in_ready; out_data lane t and out_valid[t]=1 SHALL appear on the next cycle (latency 1).
REQ-017 SHALL hold lane data and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL clear out_valid[k] after out_valid[k] & out_ready[k] unless lane k is reloaded in the same cycle.
REQ-019 SHALL, on simultaneous drain and accept on lane t, keep out_valid[t]=1 and replace data with the new word (no bubble).
REQ-020 SHALL allow all lanes to drain independently in the same cycle.
REQ-021 SHALL increment rr_ptr by 1 on each accept in rr_mode=1, wrapping 3 -> 0; rr_ptr SHALL hold in rr_mode=0 and when no accept.
REQ-022 SHALL increment xfer_cnt on every accept, wrapping 0xFFFF -> 0x0000.
REQ-023 SHALL never write a lane not equal to t; non-target lanes only drain.

Reset
REQ-024 SHALL on rst=1 immediately force out_valid=4'b0000, out_data=0, rr_ptr=0, xfer_cnt=0, independent of clk.
REQ-025 SHALL drive in_ready=0 while rst=1; words presented during reset SHALL be dropped and not counted.
REQ-026 SHALL, on reset mid-operation, discard all held lane data; first accept after release goes to lane 0 in rr_mode=1.

Structure
REQ-027 SHALL take WAYS=4, SEL_W=2, CNT_W=16 from shared package mux_pkg.
REQ-028 SHALL implement each lane as sub-module demux_lane (one-entry register with load, drain, valid flag), instantiated 4 times.
REQ-029 SHALL contain no latches and no combinational path from out_ready to out_valid/out_data.

Verification
REQ-030 SHALL cover: rr_mode=1, out_ready=4'hF, words 0x11,0x22,0x33,0x44,0x55 back-to-back -> lanes 0..3 get 0x11..0x44, lane 0 then 0x55; rr_ptr 0,1,2,3,0,1; xfer_cnt=5.
REQ-031 SHALL cover: rr_mode=0, sel=2, out_ready=0, words 0xA5,0x5A -> 0xA5 on lane 2, in_ready=0 after, 0x5A held off until out_ready[2]=1, then lane 2 = 0x5A next cycle.
REQ-032 SHALL cover: lane 1 full 0x10, out_ready[1]=1 and accept 0x20 to lane 1 same cycle -> out_valid[1] stays 1, data 0x20 next cycle, xfer_cnt +1.
REQ-033 SHALL cover: rr_mode toggled 1->0 with rr_ptr=3, sel=0, word 0x77 -> lands on lane 0, rr_ptr remains 3.
REQ-034 SHALL cover: xfer_cnt preloaded by 65535 accepts, one more accept -> xfer_cnt=0x0000.
REQ-035 SHALL cover: rst asserted mid-cycle with lanes 0,2 valid -> out_valid=0 before next clk edge, rr_ptr=0, in_ready=0 during reset.
